ring_counter_param: RTL and testbench

Parametrised ring counter with a run/stop control. It supports two modes: plain one-hot ring and Johnson (twisted-ring).
- Direction is selectable.
- Parallel load is synchronous.
- Illegal states self-correct.
- A wrap pulse and a lap counter are provided.

It is the general sequencing/one-hot strobe source for timing and scanning blocks in the Counters and Timers group. It supersedes the fixed 8-bit ring counter.

---
 rtl/ring_counter_param.sv | 110 +++++++++++
 tb/tb_ring_counter_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ring_counter_param.sv
// Parametrised ring / Johnson counter with run/stop, direction, synchronous load,
// illegal-state self-correction, a wrap pulse and a lap counter.
module ring_counter_param #(
  parameter int WIDTH     = 8,
  parameter int LAP_WIDTH = 8
) (
  input  logic                 Clk_In,
  input  logic                 Reset_In,
  input  logic                 Start_Stopb_In,
  input  logic                 Mode_In,
  input  logic                 Dir_In,
  input  logic                 Load_In,
  input  logic [WIDTH-1:0]     Load_Data_In,
  output logic [WIDTH-1:0]     Count_Out,
  output logic                 Wrap_Out,
  output logic [LAP_WIDTH-1:0] Lap_Count_Out,
  output logic                 Illegal_Out
);

  localparam logic [WIDTH-1:0]     HOME    = WIDTH'(1'b1);
  localparam logic [LAP_WIDTH-1:0] LAP_ONE = LAP_WIDTH'(1'b1);

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  function automatic logic onehot_ok(input logic [WIDTH-1:0] c);
    return (c != '0) && ((c & (c - HOME)) == '0);
  endfunction

  // Thermometer from the LSB (0..01..1) or, via the complement, from the MSB (1..10..0).
  function automatic logic johnson_ok(input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] nc;
    nc = ~c;
    return ((c & (c + HOME)) == '0) || ((nc & (nc + HOME)) == '0);
  endfunction

  logic [WIDTH-1:0]     count_r;
  logic [LAP_WIDTH-1:0] lap_r;
  logic                 wrap_r;
  logic                 illegal_r;

  logic                 legal_s;
  logic [WIDTH-1:0]     step_s;
  logic [WIDTH-1:0]     count_nx_s;
  logic [LAP_WIDTH-1:0] lap_nx_s;
  logic                 wrap_nx_s;
  logic                 illegal_nx_s;

  // Legality of the present state under the present mode, and the one-step successor.
  always_comb begin
    legal_s = 1'b0;
    step_s  = count_r;
    if (Mode_In) begin
      legal_s = johnson_ok(count_r);
    end else begin
      legal_s = onehot_ok(count_r);
    end
    case ({Mode_In, Dir_In})
      2'b00:   step_s = {count_r[WIDTH-2:0], count_r[WIDTH-1]};
      2'b01:   step_s = {count_r[0], count_r[WIDTH-1:1]};
      2'b10:   step_s = {count_r[WIDTH-2:0], ~count_r[WIDTH-1]};
      2'b11:   step_s = {~count_r[0], count_r[WIDTH-1:1]};
      default: step_s = count_r;
    endcase
  end

  // Next-state selection: load beats correction beats step beats hold.
  always_comb begin
    count_nx_s   = count_r;
    lap_nx_s     = lap_r;
    wrap_nx_s    = 1'b0;
    illegal_nx_s = 1'b0;
    if (Load_In) begin
      count_nx_s = Load_Data_In;
      lap_nx_s   = '0;
    end else if (!legal_s) begin
      count_nx_s   = HOME;
      illegal_nx_s = 1'b1;
    end else if (Start_Stopb_In) begin
      count_nx_s = step_s;
      if (step_s == HOME) begin
        wrap_nx_s = 1'b1;
        lap_nx_s  = lap_r + LAP_ONE;
      end else begin
        wrap_nx_s = 1'b0;
      end
    end else begin
      count_nx_s = count_r;
    end
  end

  // State and flag registers.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      count_r   <= HOME;
      lap_r     <= '0;
      wrap_r    <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      count_r   <= count_nx_s;
      lap_r     <= lap_nx_s;
      wrap_r    <= wrap_nx_s;
      illegal_r <= illegal_nx_s;
    end
  end

  assign Count_Out     = count_r;
  assign Lap_Count_Out = lap_r;
  assign Wrap_Out      = wrap_r;
  assign Illegal_Out   = illegal_r;

endmodule

// File: tb/tb_ring_counter_param.sv
// Self-checking bench for ring_counter_param (WIDTH = 8, LAP_WIDTH = 8):
// vector tables plus hand sequences, expectations queued and compared after each edge.
module tb_ring_counter_param;

  typedef struct {
    logic       start;
    logic       mode;
    logic       dir;
    logic       load;
    logic [7:0] ldata;
    logic [7:0] e_count;
    logic       e_wrap;
    logic [7:0] e_lap;
    logic       e_ill;
  } vec_t;

  logic       Clk_In = 1'b0;
  logic       Reset_In = 1'b0;
  logic       Start_Stopb_In = 1'b0;
  logic       Mode_In = 1'b0;
  logic       Dir_In = 1'b0;
  logic       Load_In = 1'b0;
  logic [7:0] Load_Data_In = 8'h00;
  logic [7:0] Count_Out;
  logic       Wrap_Out;
  logic [7:0] Lap_Count_Out;
  logic       Illegal_Out;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t sb_q[$];
  vec_t tbl[64];
  int   n_tbl;

  ring_counter_param #(.WIDTH(8), .LAP_WIDTH(8)) dut (
    .Clk_In(Clk_In), .Reset_In(Reset_In), .Start_Stopb_In(Start_Stopb_In),
    .Mode_In(Mode_In), .Dir_In(Dir_In), .Load_In(Load_In), .Load_Data_In(Load_Data_In),
    .Count_Out(Count_Out), .Wrap_Out(Wrap_Out), .Lap_Count_Out(Lap_Count_Out),
    .Illegal_Out(Illegal_Out)
  );

  always #5 Clk_In = ~Clk_In;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t e);
    check({tag, ".count"}, 32'(Count_Out), 32'(e.e_count));
    check({tag, ".wrap"}, 32'(Wrap_Out), 32'(e.e_wrap));
    check({tag, ".lap"}, 32'(Lap_Count_Out), 32'(e.e_lap));
    check({tag, ".illegal"}, 32'(Illegal_Out), 32'(e.e_ill));
  endtask

  // Drive one vector, queue its expectation, compare after the edge.
  task automatic apply(input string tag, input vec_t v);
    vec_t e;
    Start_Stopb_In = v.start;
    Mode_In        = v.mode;
    Dir_In         = v.dir;
    Load_In        = v.load;
    Load_Data_In   = v.ldata;
    sb_q.push_back(v);
    @(posedge Clk_In);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_all(tag, e);
    end
    Load_In = 1'b0;
  endtask

  function automatic vec_t mk(input logic st, input logic md, input logic dr, input logic ld,
                              input logic [7:0] d, input logic [7:0] c, input logic w,
                              input logic [7:0] l, input logic il);
    vec_t v;
    v.start = st; v.mode = md; v.dir = dr; v.load = ld; v.ldata = d;
    v.e_count = c; v.e_wrap = w; v.e_lap = l; v.e_ill = il;
    return v;
  endfunction

  task automatic add(input vec_t v);
    tbl[n_tbl] = v;
    n_tbl++;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < n_tbl; i++) apply($sformatf("%s[%0d]", tag, i), tbl[i]);
    n_tbl = 0;
  endtask

  task automatic do_reset(input string tag);
    vec_t e;
    Reset_In = 1'b1;
    #1;
    e = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 8'h00, 1'b0);
    check_all(tag, e);
    @(negedge Clk_In);
    Reset_In = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic [7:0] ring_seq [8];
    logic [7:0] john_seq [16];
    ring_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    john_seq = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE,
                 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};
    n_tbl = 0;

    // 1: ring toward MSB, one full revolution
    do_reset("t1.rst");
    for (int i = 0; i < 8; i++)
      add(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, ring_seq[i], (i == 7), (i == 7) ? 8'h01 : 8'h00, 1'b0));
    run_table("t1");

    // 2: ring toward LSB, hold, resume
    do_reset("t2.rst");
    add(mk(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h80, 1'b0, 8'h00, 1'b0));
    add(mk(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h40, 1'b0, 8'h00, 1'b0));
    add(mk(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 1'b0, 8'h00, 1'b0));
    for (int i = 0; i < 5; i++)
      add(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 1'b0, 8'h00, 1'b0));
    add(mk(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h10, 1'b0, 8'h00, 1'b0));
    run_table("t2");

    // 3: Johnson toward MSB, full 16-step period
    do_reset("t3.rst");
    for (int i = 0; i < 16; i++)
      add(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, john_seq[i], (i == 15), (i == 15) ? 8'h01 : 8'h00, 1'b0));
    run_table("t3");

    // 4: illegal load while stopped, then correction pulse
    add(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h05, 1'b0, 8'h00, 1'b0));
    add(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 8'h00, 1'b1));
    add(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 8'h00, 1'b0));
    run_table("t4");

    // 5: mode switch at 04 corrects; at 01 it carries on as Johnson
    add(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 8'h00, 1'b0));
    add(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 1'b0, 8'h00, 1'b0));
    add(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 8'h00, 1'b1));
    add(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 8'h00, 1'b0));
    add(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0, 8'h00, 1'b0));
    add(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h07, 1'b0, 8'h00, 1'b0));
    run_table("t5");

    // Boundary: all-zero is legal Johnson; its step lands on HOME and wraps.
    // Load also wins over a pending correction and over a running step.
    add(mk(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
    add(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
    add(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 8'h01, 1'b0));
    add(mk(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h01, 1'b0));
    add(mk(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h80, 1'b0, 8'h01, 1'b0));
    add(mk(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0));
    add(mk(1'b1, 1'b1, 1'b0, 1'b1, 8'h81, 8'h81, 1'b0, 8'h00, 1'b0));
    add(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 8'h00, 1'b1));
    run_table("t5b");

    // 6: 256 ring revolutions -> lap rolls FF -> 00, then one more lap
    do_reset("t6.rst");
    for (int i = 1; i <= 2056; i++) begin
      v = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01 << (i % 8), (i % 8 == 0),
             8'((i / 8) % 256), 1'b0);
      apply($sformatf("t6[%0d]", i), v);
    end
    // Wrap is high and lap is 1 here; reset mid-cycle must clear everything at once.
    #2;
    Reset_In = 1'b1;
    #1;
    v = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 8'h00, 1'b0);
    check_all("t6.async_rst", v);
    @(negedge Clk_In);
    Reset_In = 1'b0;
    Start_Stopb_In = 1'b0;
    @(posedge Clk_In);
    #1;
    check_all("t6.after_rst", v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
